// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state type and latency helper for seq_multiplier
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} seq_mult_state_t;
  function automatic int seq_mult_latency(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/adder.sv
// adder: parallelism-bit adder, overflow discarded; ARCH_TYPE 1 forces ripple-carry
module adder #(
  parameter int parallelism = 32,
  parameter int ARCH_TYPE = 0
) (
  input  logic [parallelism-1:0] add1,
  input  logic [parallelism-1:0] add0,
  input  logic                   carry_in,
  output logic [parallelism-1:0] sum
);
  if (ARCH_TYPE == 1) begin : g_rca
    always_comb begin
      logic c;
      c = carry_in;
      sum = '0;
      for (int i = 0; i < parallelism; i++) begin
        sum[i] = add1[i] ^ add0[i] ^ c;
        c = (add1[i] & add0[i]) | (c & (add1[i] ^ add0[i]));
      end
    end
  end else begin : g_syn
    assign sum = add1 + add0 + {{(parallelism-1){1'b0}}, carry_in};
  end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-and-add multiplier, W iterations through one W+1-bit adder.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and result.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int parallelism = 32,
  parameter int ARCH_TYPE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [parallelism-1:0]     op_a,
  input  logic [parallelism-1:0]     op_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*parallelism-1:0]   product
);
  localparam int W = parallelism;
  localparam int CW = $clog2(W);
  seq_mult_state_t state_q;
  logic [W-1:0] m_q, a_mag, b_mag;
  logic [2*W-1:0] p_q, next_p, res, product_q;
  logic [CW-1:0] cnt_q;
  logic fin_q, last;
  logic [W:0] sum;
  adder #(.parallelism(W + 1), .ARCH_TYPE(ARCH_TYPE)) u_adder (
    .add1({1'b0, p_q[2*W-1:W]}),
    .add0(p_q[0] ? {1'b0, m_q} : '0),
    .carry_in(1'b0),
    .sum(sum)
  );
  assign next_p = {sum, p_q[W-1:1]};
  assign last = cnt_q == CW'(W - 1);
`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q;
  assign a_mag = op_a[W-1] ? -op_a : op_a;
  assign b_mag = op_b[W-1] ? -op_b : op_b;
  assign res = sign_q ? -next_p : next_p;
`else
  assign a_mag = op_a;
  assign b_mag = op_b;
  assign res = next_p;
`endif
  // fin_q adds one settle cycle after the last iteration so out_valid lands at accept+W+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      fin_q <= 1'b0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q <= 1'b0;
`endif
    end else if (state_q == IDLE && in_valid) begin
      m_q <= a_mag;
      p_q <= {{W{1'b0}}, b_mag};
      cnt_q <= '0;
      state_q <= BUSY;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q <= op_a[W-1] ^ op_b[W-1];
`endif
    end else if (state_q == BUSY) begin
      if (fin_q) begin
        fin_q <= 1'b0;
        state_q <= DONE;
      end else begin
        p_q <= next_p;
        cnt_q <= last ? cnt_q : cnt_q + 1'b1;
        fin_q <= last;
        if (last) product_q <= res;
      end
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random products checked against plain arithmetic, W=8.
module tb_seq_multiplier;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [7:0] op_a = '0, op_b = '0;
  logic [15:0] product;
  int n_cmp = 0, n_bad = 0;
  seq_multiplier #(.parallelism(8), .ARCH_TYPE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [15:0] x, y;
    x = $signed(a);
    y = $signed(b);
`else
    logic [15:0] x, y;
    x = a;
    y = b;
`endif
    return x * y;
  endfunction
  task automatic mul(input logic [7:0] a, input logic [7:0] b, input int hold);
    int n;
    logic busy_ready;
    logic [15:0] exp;
    exp = model(a, b);
    chk("idle_ready", in_ready, 1);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    n = 0;
    busy_ready = 1'b0;
    while (!out_valid && n < 40) begin
      busy_ready |= in_ready;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
    chk("busy_in_ready", busy_ready, 0);
    for (int i = 0; i < hold; i++) begin
      chk("hold_product", product, exp);
      chk("hold_valid", out_valid, 1);
      chk("done_in_ready", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("product", product, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mul(8'd13, 8'd11, 0);
    mul(8'd255, 8'd255, 1);
    mul(8'd0, 8'd200, 0);
    mul(8'd1, 8'd200, 0);
    mul(8'd7, 8'd9, 5);
    op_a = 8'd50;
    op_b = 8'd77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_product", product, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mul(8'd3, 8'd3, 0);
`ifdef SEQ_MULT_SIGNED_EN
    mul(8'hFD, 8'd5, 0);
    mul(8'h80, 8'h80, 2);
    mul(8'd127, 8'hFF, 0);
`endif
    for (int i = 0; i < 24; i++) mul(8'($urandom), 8'($urandom), $urandom_range(0, 3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
